// File: rtl/enc_pkg.sv
// Shared constants, types and helpers for the priority encoder slice.
package enc_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Index width that stays at least one bit wide even for tiny request vectors.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_IDX_W = clog2_safe(DEFAULT_WIDTH);

  typedef logic [DEFAULT_IDX_W-1:0] idx_t;

endpackage

// File: rtl/prio_scan_comb.sv
// Combinational lowest-set-bit scan: bit 0 has the highest priority.
module prio_scan_comb
  import enc_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int IDX_W = clog2_safe(WIDTH)
) (
  input  logic [WIDTH-1:0] d,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic [WIDTH-1:0] onehot
);

  logic found;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    // Once a winner is found, !found masks higher bits, so X/Z above it cannot leak in.
    for (int i = 0; i < WIDTH; i++) begin
      if (!found && d[i]) begin
        found     = 1'b1;
        idx       = IDX_W'(i);
        onehot[i] = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/priority_encoder.sv
// Registered priority encoder: one-cycle latency index, valid and one-hot grant.
module priority_encoder
  import enc_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int IDX_W = clog2_safe(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic             V,
  output logic [IDX_W-1:0] a,
  output logic [WIDTH-1:0] onehot
);

  logic [IDX_W-1:0] scan_idx;
  logic             scan_any;
  logic [WIDTH-1:0] scan_onehot;

  prio_scan_comb #(.WIDTH(WIDTH)) u_scan (
    .d      (d),
    .idx    (scan_idx),
    .any    (scan_any),
    .onehot (scan_onehot)
  );

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      V      <= 1'b0;
      a      <= '0;
      onehot <= '0;
    end else begin
      V      <= scan_any;
      a      <= scan_idx;
      onehot <= scan_onehot;
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Directed + exhaustive bench for priority_encoder with a queue-based scoreboard.
module tb_priority_encoder;
  import enc_pkg::*;

  typedef struct packed {
    logic       v;
    idx_t       a;
    logic [7:0] oh;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d   = 8'h00;
  logic       V;
  idx_t       a;
  logic [7:0] onehot;

  exp_t exp_q[$];
  exp_t last_exp;
  bit   have_last = 1'b0;
  int   total = 0;
  int   bad   = 0;

  priority_encoder #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .d      (d),
    .V      (V),
    .a      (a),
    .onehot (onehot)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic v, input idx_t ai, input logic [7:0] oh);
    exp_t e;
    e.v  = v;
    e.a  = ai;
    e.oh = oh;
    return e;
  endfunction

  // Reference: first bit that is definitely 1, scanning from bit 0.
  function automatic exp_t model(input logic [7:0] dv);
    exp_t e;
    bit   hit;
    e   = mk(1'b0, '0, 8'h00);
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!hit && dv[i] === 1'b1) begin
        hit  = 1'b1;
        e.v  = 1'b1;
        e.a  = idx_t'(i);
        e.oh = 8'h01 << i;
      end
    end
    return e;
  endfunction

  // Drive at negedge, confirm outputs have not moved yet, then check one edge later.
  task automatic step(input string tag, input logic r, input logic [7:0] dv, input exp_t e);
    exp_t got;
    @(negedge clk);
    rst = r;
    d   = dv;
    exp_q.push_back(e);
    #1;
    if (have_last) begin
      total++;
      assert ({V, a, onehot} === {last_exp.v, last_exp.a, last_exp.oh}) else begin
        bad++;
        $error("FAIL %s/hold: got V=%b a=%0d oh=%h expected V=%b a=%0d oh=%h",
               tag, V, a, onehot, last_exp.v, last_exp.a, last_exp.oh);
      end
    end
    @(posedge clk);
    #1;
    total++;
    assert (exp_q.size() == 1) else begin
      bad++;
      $error("FAIL %s/queue: got depth=%0d expected depth=1", tag, exp_q.size());
    end
    if (exp_q.size() != 0) begin
      got = exp_q.pop_front();
      total++;
      assert ({V, a, onehot} === {got.v, got.a, got.oh}) else begin
        bad++;
        $error("FAIL %s: got V=%b a=%0d oh=%h expected V=%b a=%0d oh=%h",
               tag, V, a, onehot, got.v, got.a, got.oh);
      end
      total++;
      assert (!$isunknown({V, a, onehot})) else begin
        bad++;
        $error("FAIL %s/xfree: got V=%b a=%b oh=%b expected no X", tag, V, a, onehot);
      end
      last_exp  = got;
      have_last = 1'b1;
    end
  endtask

  initial begin
    // Reset held for two edges with all requests asserted.
    step("rst0", 1'b1, 8'hFF, mk(1'b0, 3'd0, 8'h00));
    step("rst1", 1'b1, 8'hFF, mk(1'b0, 3'd0, 8'h00));
    step("rel",  1'b0, 8'hFF, mk(1'b1, 3'd0, 8'h01));

    step("empty", 1'b0, 8'b0000_0000, mk(1'b0, 3'd0, 8'h00));
    step("msb",   1'b0, 8'b1000_0000, mk(1'b1, 3'd7, 8'h80));
    step("lsb",   1'b0, 8'b0000_0001, mk(1'b1, 3'd0, 8'h01));

    step("x6", 1'b0, 8'bx100_0000, mk(1'b1, 3'd6, 8'h40));
    step("x5", 1'b0, 8'bxx10_0000, mk(1'b1, 3'd5, 8'h20));
    step("x4", 1'b0, 8'bxxx1_0000, mk(1'b1, 3'd4, 8'h10));
    step("x3", 1'b0, 8'bxxxx_1000, mk(1'b1, 3'd3, 8'h08));
    step("x2", 1'b0, 8'bxxxx_x100, mk(1'b1, 3'd2, 8'h04));
    step("x1", 1'b0, 8'bxxxx_xx10, mk(1'b1, 3'd1, 8'h02));
    step("x0", 1'b0, 8'bxxxx_xxx1, mk(1'b1, 3'd0, 8'h01));

    step("multi_a", 1'b0, 8'b1010_0100, mk(1'b1, 3'd2, 8'h04));
    step("multi_b", 1'b0, 8'b1111_1110, mk(1'b1, 3'd1, 8'h02));

    // Back-to-back changes, then a one-cycle reset with a request pending.
    step("lat0", 1'b0, 8'h30, mk(1'b1, 3'd4, 8'h10));
    step("lat1", 1'b0, 8'h06, mk(1'b1, 3'd1, 8'h02));
    step("lat2", 1'b0, 8'h40, mk(1'b1, 3'd6, 8'h40));
    step("mrst", 1'b1, 8'h10, mk(1'b0, 3'd0, 8'h00));
    step("mrel", 1'b0, 8'h10, mk(1'b1, 3'd4, 8'h10));

    for (int v = 0; v < 256; v++) begin
      logic [7:0] dv;
      dv = 8'(v);
      step($sformatf("sweep%0d", v), 1'b0, dv, model(dv));
      total++;
      assert (V === (|dv)) else begin
        bad++;
        $error("FAIL sweep%0d/valid: got V=%b expected V=%b", v, V, |dv);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
